ex_muldiv_unit: RTL

- Execute-stage consumer of the ID/EX pipeline register outputs for MULT, MULTU, DIV and DIVU instructions.
- Iterative radix-2 engine: shift-add for multiply, restoring division for divide.
- Owns the architectural HI/LO registers.
- Drives a stall to the hazard logic so ID/EX and IF/ID hold while an operation is in flight.

---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/ex_muldiv_datapath.sv | 80 ++++++++
 rtl/ex_muldiv_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and the iteration counter width.
package ex_muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } md_state_e;

   localparam int MD_WIDTH = 32;

   // The counter must reach WIDTH-1, so clog2(WIDTH) bits suffice.
   function automatic int mdCntW(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

   localparam int MD_CNT_W = mdCntW(MD_WIDTH);

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide datapath.
// Works on magnitudes; the result signs are applied combinationally for FIX.
module ex_muldiv_datapath
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             zeroDiv,
   input  md_op_e           op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [WIDTH-1:0] resHi,
   output logic [WIDTH-1:0] resLo
);

   logic               isMul, negRes, negRem;
   logic [WIDTH-1:0]   bReg, hiReg, loReg;
   logic               isSigned, aNeg, bNeg;
   logic [WIDTH-1:0]   aMag, bMag;
   logic [WIDTH:0]     mulSum, divShift, divDiff;
   logic [2*WIDTH-1:0] prod, prodFix;

   assign isSigned = (op == MD_MULT) || (op == MD_DIV);
   assign aNeg     = isSigned & rs_data[WIDTH-1];
   assign bNeg     = isSigned & rt_data[WIDTH-1];
   assign aMag     = aNeg ? -rs_data : rs_data;
   assign bMag     = bNeg ? -rt_data : rt_data;

   assign mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, bReg} : '0);
   // Partial remainder stays below the divisor, so bit WIDTH of the
   // difference is a reliable borrow flag.
   assign divShift = {hiReg, loReg[WIDTH-1]};
   assign divDiff  = divShift - {1'b0, bReg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isMul  <= 1'b0;
         negRes <= 1'b0;
         negRem <= 1'b0;
         bReg   <= '0;
         hiReg  <= '0;
         loReg  <= '0;
      end else if (load) begin
         isMul  <= ~op[1];
         negRes <= ~zeroDiv & (aNeg ^ bNeg);
         negRem <= ~zeroDiv & op[1] & aNeg;
         bReg   <= bMag;
         // A zero divide preloads its final answer; FIX passes it through.
         hiReg  <= zeroDiv ? rs_data : '0;
         loReg  <= zeroDiv ? '1 : aMag;
      end else if (step) begin
         if (isMul) begin
            {hiReg, loReg} <= {mulSum, loReg[WIDTH-1:1]};
         end else if (!divDiff[WIDTH]) begin
            hiReg <= divDiff[WIDTH-1:0];
            loReg <= {loReg[WIDTH-2:0], 1'b1};
         end else begin
            hiReg <= {hiReg[WIDTH-2:0], loReg[WIDTH-1]};
            loReg <= {loReg[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign prod    = {hiReg, loReg};
   assign prodFix = negRes ? -prod : prod;

   always_comb begin
      resHi = negRem ? -hiReg : hiReg;
      resLo = negRes ? -loReg : loReg;
      if (isMul) begin
         resHi = prodFix[2*WIDTH-1:WIDTH];
         resLo = prodFix[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MULT/MULTU/DIV/DIVU unit: FSM, iteration counter, stall/done
// and the architectural HI/LO registers.
module ex_muldiv_unit
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = mdCntW(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e        state, stateNext;
   logic [CW-1:0]    cnt;
   logic             zeroReq, zeroPend, accept;
   logic [WIDTH-1:0] resHi, resLo;

   assign zeroReq = op[1] && (rt_data == '0);
   assign accept  = (state == IDLE) && start && !flush;
   assign stall   = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      if (flush) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) stateNext = zeroReq ? FIX : RUN;
            RUN:     if (cnt == LAST) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         zeroPend    <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= (state == FIX) && !flush;
         cnt  <= (state == RUN && !flush) ? cnt + 1'b1 : '0;
         if (accept) begin
            zeroPend    <= zeroReq;
            div_by_zero <= 1'b0;
         end
         // A flushed op never reaches here, so HI/LO keep their old values.
         if (state == FIX && !flush) begin
            hi          <= resHi;
            lo          <= resLo;
            div_by_zero <= zeroPend;
         end
      end
   end

   ex_muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .step    (state == RUN),
      .zeroDiv (zeroReq),
      .op      (md_op_e'(op)),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .resHi   (resHi),
      .resLo   (resLo)
   );

endmodule
